traffic_light_multi: RTL and testbench

- Parametrised successor to the single-intersection controller: round-robin sequencing of NUM_PHASES signal groups, each Green -> Yellow -> All-Red.
- Adds a pedestrian walk phase, inserted after any yellow when a request is pending.
- Adds a tick prescaler for real-time durations and a yellow flash (night/fault) mode.
- Sits between board I/O (button, mode switch) and the LED bank.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 27 ++
 rtl/traffic_light_multi.sv | 176 +++++++++++++++++
 tb/tb_traffic_light_multi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp codes, walk-lamp codes and FSM state codes for the multi-phase
// traffic light controller.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [1:0] WALK_ON  = 2'b01;
    localparam logic [1:0] WALK_OFF = 2'b10;

    localparam logic [2:0] S_GREEN  = 3'd0;
    localparam logic [2:0] S_YELLOW = 3'd1;
    localparam logic [2:0] S_ALLRED = 3'd2;
    localparam logic [2:0] S_WALK   = 3'd3;
    localparam logic [2:0] S_FLASH  = 3'd4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one clock every TICK_DIV clocks.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic sys_clkp,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_q;

    assign tick = (count_q == CW'(TICK_DIV - 1));

    // Only reset clears the count; FSM state changes never touch it.
    always_ff @(posedge sys_clkp) begin
        if (rst) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin controller for NUM_PHASES signal groups with a pedestrian walk
// phase after yellow on request, and a yellow flash (night/fault) mode.
module traffic_light_multi
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES    = 2,
    parameter int TICK_DIV      = 1,
    parameter int TIMER_W       = 16,
    parameter int GREEN_TICKS   = 9,
    parameter int YELLOW_TICKS  = 4,
    parameter int ALL_RED_TICKS = 1,
    parameter int WALK_TICKS    = 10,
    parameter int FLASH_TICKS   = 2
) (
    input  logic                          sys_clkp,
    input  logic                          rst,
    input  logic                          button,
    input  logic                          flash_en,
    output logic [3*NUM_PHASES-1:0]       lights,
    output logic [1:0]                    walk,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [2:0]                    state
);

    localparam int PW = $clog2(NUM_PHASES);

    logic               tick;
    logic               sync_meta;
    logic               sync_level;
    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [PW-1:0]      phase_q;
    logic [PW-1:0]      phase_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [TIMER_W-1:0] dur_m1;
    logic               expire;
    logic               pending_q;
    logic               pending_d;
    logic               blink_q;
    logic               blink_d;
    logic               from_flash_q;
    logic               from_flash_d;
    logic               flash_entry;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .sys_clkp (sys_clkp),
        .rst      (rst),
        .tick     (tick)
    );

    always_comb begin
        case (state_q)
            S_GREEN:  dur_m1 = TIMER_W'(GREEN_TICKS - 1);
            S_YELLOW: dur_m1 = TIMER_W'(YELLOW_TICKS - 1);
            S_WALK:   dur_m1 = TIMER_W'(WALK_TICKS - 1);
            S_FLASH:  dur_m1 = TIMER_W'(FLASH_TICKS - 1);
            default:  dur_m1 = TIMER_W'(ALL_RED_TICKS - 1);
        endcase
    end

    assign expire      = tick && (timer_q == dur_m1);
    assign flash_entry = flash_en && (state_q != S_FLASH);

    // Flash request outranks timer expiry; every state change restarts the timer.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        blink_d      = blink_q;
        from_flash_d = from_flash_q;
        timer_d      = tick ? timer_q + TIMER_W'(1) : timer_q;
        if (flash_entry) begin
            state_d = S_FLASH;
            timer_d = '0;
            blink_d = 1'b1;
        end else begin
            case (state_q)
                S_GREEN: begin
                    if (expire) begin
                        state_d = S_YELLOW;
                        timer_d = '0;
                    end
                end
                S_YELLOW: begin
                    if (expire) begin
                        state_d = pending_q ? S_WALK : S_ALLRED;
                        timer_d = '0;
                    end
                end
                S_WALK: begin
                    if (expire) begin
                        state_d = S_ALLRED;
                        timer_d = '0;
                    end
                end
                S_FLASH: begin
                    if (!flash_en) begin
                        state_d      = S_ALLRED;
                        timer_d      = '0;
                        from_flash_d = 1'b1;
                    end else if (expire) begin
                        blink_d = ~blink_q;
                        timer_d = '0;
                    end
                end
                default: begin
                    if (expire) begin
                        state_d      = S_GREEN;
                        timer_d      = '0;
                        from_flash_d = 1'b0;
                        if (from_flash_q || (phase_q == PW'(NUM_PHASES - 1))) begin
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + PW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        if (flash_entry || (state_q == S_WALK) || (state_q == S_FLASH)) begin
            pending_d = 1'b0;
        end else if (sync_level) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    always_ff @(posedge sys_clkp) begin
        if (rst) begin
            sync_meta    <= 1'b0;
            sync_level   <= 1'b0;
            state_q      <= S_GREEN;
            phase_q      <= '0;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            blink_q      <= 1'b0;
            from_flash_q <= 1'b0;
        end else begin
            sync_meta    <= button;
            sync_level   <= sync_meta;
            state_q      <= state_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            blink_q      <= blink_d;
            from_flash_q <= from_flash_d;
        end
    end

    // Lamps decode straight from registers so they never lag the state.
    always_comb begin
        for (int i = 0; i < NUM_PHASES; i++) begin
            lights[3*i +: 3] = RED;
            if (state_q == S_FLASH) begin
                lights[3*i +: 3] = blink_q ? YELLOW : DARK;
            end else if (phase_q == PW'(i)) begin
                if (state_q == S_GREEN) begin
                    lights[3*i +: 3] = GREEN;
                end else if (state_q == S_YELLOW) begin
                    lights[3*i +: 3] = YELLOW;
                end
            end
        end
    end

    assign walk  = (state_q == S_WALK) ? WALK_ON : WALK_OFF;
    assign phase = phase_q;
    assign state = state_q;

endmodule

// File: tb/tb_traffic_light_multi.sv
// Scoreboard bench: per-cycle expected {state, phase, lights, walk} words are
// queued from timing tables and popped one per clock against the DUT.
module tb_traffic_light_multi;

    logic       clk;
    logic       rst_a;
    logic       button_a;
    logic       flash_a;
    logic [5:0] lights_a;
    logic [1:0] walk_a;
    logic [0:0] phase_a;
    logic [2:0] state_a;

    logic       rst_b;
    logic       button_b;
    logic       flash_b;
    logic [8:0] lights_b;
    logic [1:0] walk_b;
    logic [1:0] phase_b;
    logic [2:0] state_b;

    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ST_G  = 3'd0;
    localparam logic [2:0] ST_Y  = 3'd1;
    localparam logic [2:0] ST_AR = 3'd2;
    localparam logic [2:0] ST_W  = 3'd3;
    localparam logic [2:0] ST_F  = 3'd4;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    traffic_light_multi dut_a (
        .sys_clkp (clk),
        .rst      (rst_a),
        .button   (button_a),
        .flash_en (flash_a),
        .lights   (lights_a),
        .walk     (walk_a),
        .phase    (phase_a),
        .state    (state_a)
    );

    traffic_light_multi #(
        .NUM_PHASES (3),
        .TICK_DIV   (4)
    ) dut_b (
        .sys_clkp (clk),
        .rst      (rst_b),
        .button   (button_b),
        .flash_en (flash_b),
        .lights   (lights_b),
        .walk     (walk_b),
        .phase    (phase_b),
        .state    (state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wa(input logic [2:0] s, input logic p,
                                       input logic [5:0] l, input logic [1:0] w);
        return {4'b0000, s, p, l, w};
    endfunction

    function automatic logic [15:0] wb(input logic [2:0] s, input logic [1:0] p,
                                       input logic [8:0] l, input logic [1:0] w);
        return {s, p, l, w};
    endfunction

    // driver tasks
    task automatic push_span(input int n, input logic [15:0] word);
        for (int i = 0; i < n; i++) exp_q.push_back(word);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
    endtask

    // scoreboard: first pop is the current cycle, then one pop per clock
    task automatic drain(input string tag, input bit sel_b);
        logic [15:0] got;
        logic [15:0] exp;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            got = sel_b ? {state_b, phase_b, lights_b, walk_b}
                        : {4'b0000, state_a, phase_a, lights_a, walk_a};
            exp = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, cyc), {16'h0, got}, {16'h0, exp});
            cyc++;
        end
    endtask

    initial begin
        rst_a = 1'b1; button_a = 1'b0; flash_a = 1'b0;
        rst_b = 1'b1; button_b = 1'b0; flash_b = 1'b0;
        wait_cycles(3);

        // 1: plain cycle, no requests
        reset_a();
        push_span(9, wa(ST_G,  1'b0, 6'b100_001, 2'b10));
        push_span(4, wa(ST_Y,  1'b0, 6'b100_010, 2'b10));
        push_span(1, wa(ST_AR, 1'b0, 6'b100_100, 2'b10));
        push_span(3, wa(ST_G,  1'b1, 6'b001_100, 2'b10));
        drain("plain", 1'b0);

        // 2+3: press at cycle 3 gives walk; press during walk is ignored
        reset_a();
        push_span(9,  wa(ST_G,  1'b0, 6'b100_001, 2'b10));
        push_span(4,  wa(ST_Y,  1'b0, 6'b100_010, 2'b10));
        push_span(10, wa(ST_W,  1'b0, 6'b100_100, 2'b01));
        push_span(1,  wa(ST_AR, 1'b0, 6'b100_100, 2'b10));
        push_span(9,  wa(ST_G,  1'b1, 6'b001_100, 2'b10));
        push_span(4,  wa(ST_Y,  1'b1, 6'b010_100, 2'b10));
        push_span(1,  wa(ST_AR, 1'b1, 6'b100_100, 2'b10));
        push_span(2,  wa(ST_G,  1'b0, 6'b100_001, 2'b10));
        fork
            begin
                wait_cycles(3);  #2 button_a = 1'b1;
                wait_cycles(1);  #2 button_a = 1'b0;
                wait_cycles(11); #2 button_a = 1'b1;
                wait_cycles(1);  #2 button_a = 1'b0;
            end
            drain("walk", 1'b0);
        join

        // 4: flash during phase 1 green, exit returns to phase 0
        reset_a();
        push_span(9, wa(ST_G,  1'b0, 6'b100_001, 2'b10));
        push_span(4, wa(ST_Y,  1'b0, 6'b100_010, 2'b10));
        push_span(1, wa(ST_AR, 1'b0, 6'b100_100, 2'b10));
        push_span(2, wa(ST_G,  1'b1, 6'b001_100, 2'b10));
        for (int k = 0; k < 2; k++) begin
            push_span(2, wa(ST_F, 1'b1, 6'b010_010, 2'b10));
            push_span(2, wa(ST_F, 1'b1, 6'b000_000, 2'b10));
        end
        push_span(1, wa(ST_AR, 1'b1, 6'b100_100, 2'b10));
        push_span(2, wa(ST_G,  1'b0, 6'b100_001, 2'b10));
        fork
            begin
                wait_cycles(15); #2 flash_a = 1'b1;
                wait_cycles(8);  #2 flash_a = 1'b0;
            end
            drain("flash", 1'b0);
        join

        // 5: reset in the middle of walk clears everything incl. pending
        reset_a();
        push_span(9, wa(ST_G,  1'b0, 6'b100_001, 2'b10));
        push_span(4, wa(ST_Y,  1'b0, 6'b100_010, 2'b10));
        push_span(3, wa(ST_W,  1'b0, 6'b100_100, 2'b01));
        push_span(9, wa(ST_G,  1'b0, 6'b100_001, 2'b10));
        push_span(4, wa(ST_Y,  1'b0, 6'b100_010, 2'b10));
        push_span(1, wa(ST_AR, 1'b0, 6'b100_100, 2'b10));
        push_span(1, wa(ST_G,  1'b1, 6'b001_100, 2'b10));
        fork
            begin
                wait_cycles(3);  #2 button_a = 1'b1;
                wait_cycles(1);  #2 button_a = 1'b0;
                wait_cycles(11); #2 rst_a = 1'b1;
                wait_cycles(1);  #2 rst_a = 1'b0;
            end
            drain("rstwalk", 1'b0);
        join

        // 6: three phases, four clocks per tick, wrap back to phase 0
        reset_b();
        for (int p = 0; p < 3; p++) begin
            logic [8:0] g_l;
            logic [8:0] y_l;
            g_l = 9'b100_100_100;
            y_l = 9'b100_100_100;
            g_l[3*p +: 3] = 3'b001;
            y_l[3*p +: 3] = 3'b010;
            push_span(36, wb(ST_G,  2'(p), g_l, 2'b10));
            push_span(16, wb(ST_Y,  2'(p), y_l, 2'b10));
            push_span(4,  wb(ST_AR, 2'(p), 9'b100_100_100, 2'b10));
        end
        push_span(2, wb(ST_G, 2'd0, 9'b100_100_001, 2'b10));
        drain("multi", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
